// File: rtl/mac_node_pipe.sv
// rtl/mac_node_pipe.sv - pipelined fixed-point MAC neuron with bias, saturation and activation
module mac_node_pipe #(
  parameter int N_INPUTS = 64,
  parameter int LANES    = 4,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int ACC_W    = 40
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start,
  input  logic                      clear,
  input  logic [1:0]                act_mode,
  input  logic [DATA_W-1:0]         bias,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   coef_in,
  input  logic [LANES*DATA_W-1:0]   data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         node_out,
  output logic                      busy,
  output logic                      overflow
);

  localparam int BEATS = N_INPUTS / LANES;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int PW    = 2 * DATA_W;
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUTPUT} state_t;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [PW-1:0]     prod_q [LANES];
  logic signed [PW-1:0]     prod_d [LANES];
  logic                     prod_vld_q, prod_vld_d;
  logic [1:0]               mode_q, mode_d;
  logic signed [DATA_W-1:0] res_q, res_d;
  logic                     res_ovf_q, res_ovf_d;
  logic                     drain_q, drain_d;
  logic [DATA_W-1:0]        node_out_q, node_out_d;
  logic                     overflow_q, overflow_d;

  logic                     accept;
  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  r_full;
  logic [ACC_W-DATA_W:0]    r_hi;
  logic signed [DATA_W-1:0] sat_v;
  logic                     sat_ovf;
  logic signed [DATA_W-1:0] act_v;

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clear returns to IDLE from anywhere and wins over start
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACCUM;
      S_ACCUM:  if (cnt_q == BEATS_C) state_d = S_DRAIN;
      S_DRAIN:  if (drain_q) state_d = S_OUTPUT;
      S_OUTPUT: if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = (state_q == S_ACCUM) && (cnt_q < BEATS_C);
    out_valid = (state_q == S_OUTPUT);
    busy      = (state_q != S_IDLE);
    node_out  = node_out_q;
    overflow  = overflow_q;
  end

  // Lane products, lane sum, and saturation / activation of the finished accumulator
  always_comb begin
    accept   = in_valid && in_ready;
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = $signed(coef_in[i*DATA_W +: DATA_W]) * $signed(data_in[i*DATA_W +: DATA_W]);
      lane_sum  = lane_sum + {{(ACC_W-PW){prod_q[i][PW-1]}}, prod_q[i]};
    end
    // Everything above the DATA_W-1 sign bit must be a copy of it, else clamp
    r_full = acc_q >>> FRAC_W;
    r_hi   = r_full[ACC_W-1:DATA_W-1];
    if ((r_hi == '0) || (r_hi == '1)) begin
      sat_v   = r_full[DATA_W-1:0];
      sat_ovf = 1'b0;
    end else begin
      sat_v   = r_full[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      sat_ovf = 1'b1;
    end
    act_v = res_q;
    if (res_q[DATA_W-1]) begin
      if (mode_q == 2'd1)      act_v = '0;
      else if (mode_q == 2'd2) act_v = res_q >>> 3;
    end
  end

  // Datapath next values: bias load, beat counting, accumulate, two-stage drain
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    prod_vld_d = accept;
    mode_d     = mode_q;
    res_d      = res_q;
    res_ovf_d  = res_ovf_q;
    drain_d    = drain_q;
    node_out_d = node_out_q;
    overflow_d = overflow_q;
    if (prod_vld_q) acc_d = acc_q + lane_sum;
    if (accept)     cnt_d = cnt_q + 1'b1;
    if ((state_q == S_IDLE) && start && !clear) begin
      acc_d      = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
      cnt_d      = '0;
      mode_d     = act_mode;
      overflow_d = 1'b0;
      drain_d    = 1'b0;
    end
    if (state_q == S_DRAIN) begin
      if (!drain_q) begin
        res_d     = sat_v;
        res_ovf_d = sat_ovf;
        drain_d   = 1'b1;
      end else begin
        node_out_d = act_v;
        overflow_d = res_ovf_q;
        drain_d    = 1'b0;
      end
    end
    if (clear) begin
      prod_vld_d = 1'b0;
      drain_d    = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      prod_vld_q <= 1'b0;
      mode_q     <= '0;
      res_q      <= '0;
      res_ovf_q  <= 1'b0;
      drain_q    <= 1'b0;
      node_out_q <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      prod_vld_q <= prod_vld_d;
      mode_q     <= mode_d;
      res_q      <= res_d;
      res_ovf_q  <= res_ovf_d;
      drain_q    <= drain_d;
      node_out_q <= node_out_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
    end
  end

endmodule
